// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port between scalar and vector requesters
// Optional fixed scalar priority: define DMEM_ARB_SCALAR_PRIO_EN.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_gnt,
    output logic              s_done,
    output logic [DATA_W-1:0] s_rdata,
    input  logic              v_req,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [DATA_W-1:0] v_wdata,
    output logic              v_gnt,
    output logic              v_done,
    output logic [DATA_W-1:0] v_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_enable
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick_v;

`ifdef DMEM_ARB_SCALAR_PRIO_EN
    always_comb begin
        pick_v = !s_req;
    end
`else
    logic last_owner_q, last_owner_d;

    // owner/last_owner encoding: 1 = vector, 0 = scalar
    always_comb begin
        pick_v = v_req && (!s_req || !last_owner_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && (s_req || v_req)) begin
            last_owner_d = pick_v;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= 3'd0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        s_gnt     = 1'b0;
        v_gnt     = 1'b0;
        s_done    = 1'b0;
        v_done    = 1'b0;
        s_rdata   = '0;
        v_rdata   = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (s_req || v_req) begin
                    s_gnt     = !pick_v;
                    v_gnt     = pick_v;
                    we_d      = pick_v ? v_we : s_we;
                    addr_d    = pick_v ? v_addr : s_addr;
                    wdata_d   = pick_v ? v_wdata : s_wdata;
                    mem_rd_en = !we_d;
                    mem_wr_en = we_d;
                    mem_addr  = addr_d;
                    mem_wdata = wdata_d;
                    owner_d   = pick_v;
                    lat_cnt_d = 3'd1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt_q == 3'(MEM_LAT)) begin
                    s_done    = !owner_q;
                    v_done    = owner_q;
                    s_rdata   = (!owner_q && !we_q) ? mem_rdata : '0;
                    v_rdata   = (owner_q && !we_q) ? mem_rdata : '0;
                    lat_cnt_d = 3'd0;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is held every output is forced quiet, including the stall.
        if (!rst) begin
            s_gnt     = 1'b0;
            v_gnt     = 1'b0;
            s_done    = 1'b0;
            v_done    = 1'b0;
            s_rdata   = '0;
            v_rdata   = '0;
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
        pc_enable = rst && !(s_req && !s_done);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a transaction-level reference model
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        s_req, s_we, v_req, v_we;
    logic [31:0] s_addr, s_wdata, v_addr, v_wdata;
    logic        s_gnt, s_done, v_gnt, v_done;
    logic [31:0] s_rdata, v_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        pc_enable;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst_n),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_done(s_done), .s_rdata(s_rdata),
        .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_gnt(v_gnt), .v_done(v_done), .v_rdata(v_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc_enable(pc_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction in flight, finishing LAT cycles after issue.
    bit          busy = 0;
    bit          m_owner_v;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, exp_rd;
    int          done_cyc;
    bit          last_v = 1;
    logic [31:0] mem [logic [31:0]];

    int s_gnt_cyc = -1, s_done_cyc = -1, v_gnt_cyc = -1, v_done_cyc = -1;
    int v_gnt_count = 0, any_done_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit          e_sg, e_vg, e_sd, e_vd, e_rd, e_wr, chk_addr, win_v;
        logic [31:0] e_srd, e_vrd, e_a, e_w;
        e_sg = 0; e_vg = 0; e_sd = 0; e_vd = 0; e_rd = 0; e_wr = 0; chk_addr = 0;
        e_srd = 0; e_vrd = 0; e_a = 0; e_w = 0; win_v = 0;

        if (rst_n && busy && cyc == done_cyc && !m_we) mem_rdata = exp_rd;
        else mem_rdata = $urandom;
        #4;

        if (!rst_n) begin
            chk_addr = 1;
        end else if (busy && cyc == done_cyc) begin
            e_sd = !m_owner_v;
            e_vd = m_owner_v;
            if (!m_we) begin
                if (m_owner_v) e_vrd = exp_rd; else e_srd = exp_rd;
            end
            chk_addr = 1; e_a = m_addr; e_w = m_wdata;
        end else if (busy) begin
            chk_addr = 1; e_a = m_addr; e_w = m_wdata;
        end else if (s_req || v_req) begin
`ifdef DMEM_ARB_SCALAR_PRIO_EN
            win_v = !s_req;
`else
            if (s_req && v_req) win_v = !last_v;
            else win_v = v_req;
`endif
            e_sg = !win_v;
            e_vg = win_v;
            m_we    = win_v ? v_we : s_we;
            m_addr  = win_v ? v_addr : s_addr;
            m_wdata = win_v ? v_wdata : s_wdata;
            e_rd = !m_we;
            e_wr = m_we;
            chk_addr = 1; e_a = m_addr; e_w = m_wdata;
        end

        chk("s_gnt", 32'(s_gnt), 32'(e_sg));
        chk("v_gnt", 32'(v_gnt), 32'(e_vg));
        chk("s_done", 32'(s_done), 32'(e_sd));
        chk("v_done", 32'(v_done), 32'(e_vd));
        chk("s_rdata", s_rdata, e_srd);
        chk("v_rdata", v_rdata, e_vrd);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
        chk("pc_enable", 32'(pc_enable), 32'(rst_n && !(s_req && !e_sd)));
        if (chk_addr) begin
            chk("mem_addr", mem_addr, e_a);
            chk("mem_wdata", mem_wdata, e_w);
        end

        if (s_gnt === 1'b1) s_gnt_cyc = cyc;
        if (s_done === 1'b1) s_done_cyc = cyc;
        if (v_gnt === 1'b1) begin v_gnt_cyc = cyc; v_gnt_count++; end
        if (v_done === 1'b1) v_done_cyc = cyc;
        if (s_done === 1'b1 || v_done === 1'b1) any_done_count++;

        if (!rst_n) begin
            busy = 0;
            last_v = 1;
        end else if (busy && cyc == done_cyc) begin
            busy = 0;
        end else if (!busy && (s_req || v_req)) begin
            busy = 1;
            m_owner_v = win_v;
            last_v = win_v;
            done_cyc = cyc + LAT;
            if (m_we) mem[m_addr] = m_wdata;
            else exp_rd = mem.exists(m_addr) ? mem[m_addr] : ~m_addr;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        for (int i = 0; i < n; i++) step();
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        mem_rdata = 0;
        do_reset(3);

        // Scalar read returning 0xDEADBEEF
        mem[32'h10] = 32'hDEADBEEF;
        s_req = 1; s_we = 0; s_addr = 32'h10;
        for (int i = 0; i <= LAT; i++) step();
        s_req = 0;
        chk("s_read_latency", 32'(s_done_cyc - s_gnt_cyc), 32'(LAT));
        step();

        // Simultaneous requests straight after reset: scalar first, then alternation
        do_reset(1);
        s_req = 1; s_addr = 32'h4; v_req = 1; v_addr = 32'h8;
        for (int i = 0; i < 4 * (LAT + 1); i++) step();
        idle_inputs();
        step();

        // Vector write
        v_req = 1; v_we = 1; v_addr = 32'h40; v_wdata = 32'h1234;
        step();
        v_req = 0;
        for (int i = 0; i < LAT; i++) step();
        chk("v_write_latency", 32'(v_done_cyc - v_gnt_cyc), 32'(LAT));

        // Reset while busy abandons the access
        s_req = 1; s_we = 0; s_addr = 32'h20;
        step();
        step();
        any_done_count = 0;
        do_reset(2);
        idle_inputs();
        for (int i = 0; i < LAT + 2; i++) step();
        chk("no_done_after_reset", 32'(any_done_count), 32'd0);
        s_req = 1; s_addr = 32'h24;
        step();
        chk("gnt_after_reset", 32'(s_gnt_cyc), 32'(cyc - 1));
        for (int i = 0; i < LAT; i++) step();
        s_req = 0;

        // Vector request withdrawn while scalar is busy
        s_req = 1; s_addr = 32'h30;
        step();
        v_req = 1; v_addr = 32'h50;
        step();
        v_req = 0;
        v_gnt_count = 0;
        for (int i = 0; i < LAT + 3; i++) step();
        s_req = 0;
        chk("withdrawn_v_gnt", 32'(v_gnt_count), 32'd0);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            s_req   = $urandom_range(0, 2) != 0;
            s_we    = $urandom_range(0, 1) == 1;
            s_addr  = 32'($urandom_range(0, 7)) << 2;
            s_wdata = $urandom;
            v_req   = $urandom_range(0, 2) != 0;
            v_we    = $urandom_range(0, 1) == 1;
            v_addr  = 32'($urandom_range(0, 7)) << 2;
            v_wdata = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
